// File: rtl/regfile_wb_queue.sv
// Write-side front end of the integer register file: an in-order writeback FIFO
// that retires one entry per cycle and forwards pending values to decode.
module regfile_wb_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wb_valid,
   output logic                       wb_ready,
   input  logic [4:0]                 wb_rd_s,
   input  logic [31:0]                wb_rd_v,
   input  logic                       drain_en,
   output logic                       regf_we,
   output logic [4:0]                 rd_s,
   output logic [31:0]                rd_v,
   input  logic [4:0]                 rs1_s,
   input  logic [4:0]                 rs2_s,
   output logic                       fwd1_hit,
   output logic [31:0]                fwd1_v,
   output logic                       fwd2_hit,
   output logic [31:0]                fwd2_v,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] val;
   } wb_entry_t;

   wb_entry_t              mem [DEPTH];
   logic [DEPTH-1:0]       vld_q;
   logic [PTR_W-1:0]       head_q;
   logic [PTR_W-1:0]       tail_q;
   logic [CNT_W-1:0]       count_q;
   logic [CNT_W-1:0]       count_d;
   logic                   empty_q;
   logic                   enq;
   logic                   deq;
   wb_entry_t              head_ent;

   // Retire port: head entry drives the regfile; nothing is written while in reset
   always_comb begin
      head_ent = mem[head_q];
      regf_we  = !rst && !empty_q && drain_en;
      rd_s     = 5'd0;
      rd_v     = 32'd0;
      if (!rst && !empty_q) begin
         rd_s = head_ent.idx;
         rd_v = head_ent.val;
      end
   end

   // Handshake; x0 writes complete the handshake but are never stored
   always_comb begin
      wb_ready = !rst && ((count_q < CNT_W'(DEPTH)) || regf_we);
      enq      = wb_valid && wb_ready && (wb_rd_s != 5'd0);
      deq      = regf_we;
      count_d  = count_q;
      if (enq && !deq) begin
         count_d = count_q + CNT_W'(1);
      end else if (!enq && deq) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pointers, valid bits and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         vld_q   <= '0;
      end else begin
         // Clear before set so a full-queue enqueue into the retiring slot stays valid
         if (deq) begin
            vld_q[head_q] <= 1'b0;
            head_q        <= head_q + PTR_W'(1);
         end
         if (enq) begin
            vld_q[tail_q] <= 1'b1;
            tail_q        <= tail_q + PTR_W'(1);
         end
         count_q <= count_d;
         empty_q <= (count_d == '0);
      end
   end

   // Payload storage needs no reset; validity is tracked by vld_q
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail_q] <= '{idx: wb_rd_s, val: wb_rd_v};
      end
   end

   // Forwarding: walk oldest to youngest so the youngest match wins
   always_comb begin
      logic [PTR_W-1:0] p;
      fwd1_hit = 1'b0;
      fwd1_v   = 32'd0;
      fwd2_hit = 1'b0;
      fwd2_v   = 32'd0;
      p        = head_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         p = head_q + PTR_W'(i);
         if (!rst && vld_q[p]) begin
            if ((rs1_s != 5'd0) && (mem[p].idx == rs1_s)) begin
               fwd1_hit = 1'b1;
               fwd1_v   = mem[p].val;
            end
            if ((rs2_s != 5'd0) && (mem[p].idx == rs2_s)) begin
               fwd2_hit = 1'b1;
               fwd2_v   = mem[p].val;
            end
         end
      end
   end

   assign count = count_q;
   assign empty = empty_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: a queue of pending writes predicts
// retire order, handshake, occupancy and forwarding every cycle.
module tb_regfile_wb_queue;

   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] val;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd_s;
   logic [31:0] wb_rd_v;
   logic        drain_en;
   logic        regf_we;
   logic [4:0]  rd_s;
   logic [31:0] rd_v;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic        fwd1_hit;
   logic [31:0] fwd1_v;
   logic        fwd2_hit;
   logic [31:0] fwd2_v;
   logic [2:0]  count;
   logic        empty;

   ent_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   mon_en   = 1'b0;

   regfile_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_s(wb_rd_s), .wb_rd_v(wb_rd_v),
      .drain_en(drain_en), .regf_we(regf_we), .rd_s(rd_s), .rd_v(rd_v),
      .rs1_s(rs1_s), .rs2_s(rs2_s),
      .fwd1_hit(fwd1_hit), .fwd1_v(fwd1_v), .fwd2_hit(fwd2_hit), .fwd2_v(fwd2_v),
      .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   // Youngest pending write to rs, searched from the back of the scoreboard
   function automatic void fwd_model(input logic [4:0] rs, output logic hit, output logic [31:0] v);
      hit = 1'b0;
      v   = 32'd0;
      if (rs != 5'd0 && !rst) begin
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].idx == rs) begin
               hit = 1'b1;
               v   = sb[i].val;
               break;
            end
         end
      end
   endfunction

   // Per-cycle monitor, sampled mid-cycle after inputs settle
   always @(negedge clk) begin
      logic        exp_we, exp_rdy, h;
      logic [31:0] v;
      ent_t        hd;
      #2;
      if (mon_en) begin
         exp_we  = !rst && (sb.size() != 0) && drain_en;
         exp_rdy = !rst && ((sb.size() < DEPTH) || exp_we);
         hd      = (!rst && sb.size() != 0) ? sb[0] : '0;
         check("count", 64'(count), 64'(sb.size()));
         check("empty", 64'(empty), 64'(sb.size() == 0));
         check("regf_we", 64'(regf_we), 64'(exp_we));
         check("wb_ready", 64'(wb_ready), 64'(exp_rdy));
         check("rd_s", 64'(rd_s), 64'(hd.idx));
         check("rd_v", 64'(rd_v), 64'(hd.val));
         fwd_model(rs1_s, h, v);
         check("fwd1_hit", 64'(fwd1_hit), 64'(h));
         check("fwd1_v", 64'(fwd1_v), 64'(v));
         fwd_model(rs2_s, h, v);
         check("fwd2_hit", 64'(fwd2_hit), 64'(h));
         check("fwd2_v", 64'(fwd2_v), 64'(v));
         if (rst) begin
            sb.delete();
         end else begin
            if (exp_we) void'(sb.pop_front());
            if (wb_valid && exp_rdy && wb_rd_s != 5'd0) sb.push_back('{idx: wb_rd_s, val: wb_rd_v});
         end
      end
   end

   task automatic cyc(input logic v, input logic [4:0] s, input logic [31:0] d,
                      input logic dr, input logic [4:0] r1, input logic [4:0] r2);
      @(negedge clk);
      wb_valid = v;
      wb_rd_s  = s;
      wb_rd_v  = d;
      drain_en = dr;
      rs1_s    = r1;
      rs2_s    = r2;
   endtask

   task automatic drain_all();
      int n = 0;
      while (sb.size() != 0 && n < 64) begin
         cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
         n++;
      end
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      #3;
      check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      rst = 1'b1; wb_valid = 1'b0; wb_rd_s = '0; wb_rd_v = '0;
      drain_en = 1'b0; rs1_s = '0; rs2_s = '0;
      repeat (2) @(posedge clk);
      mon_en = 1'b1;

      // Idle after reset, then single-entry latency
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      rst = 1'b0;
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);
      #3;
      check("lat_we", 64'(regf_we), 64'd1);
      check("lat_rd_s", 64'(rd_s), 64'd5);
      check("lat_rd_v", 64'(rd_v), 64'hDEADBEEF);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      #3;
      check("lat_empty", 64'(empty), 64'd1);

      // Fill with drain held, probe forwarding
      cyc(1'b1, 5'd3, 32'd1, 1'b0, 5'd0, 5'd0);
      cyc(1'b1, 5'd4, 32'd2, 1'b0, 5'd0, 5'd0);
      cyc(1'b1, 5'd3, 32'd3, 1'b0, 5'd0, 5'd0);
      cyc(1'b1, 5'd7, 32'd4, 1'b0, 5'd0, 5'd0);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd7);
      #3;
      check("full_count", 64'(count), 64'd4);
      check("full_ready", 64'(wb_ready), 64'd0);
      check("fwd1_young", 64'(fwd1_v), 64'd3);
      check("fwd2_x7", 64'(fwd2_v), 64'd4);
      cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4);
      #3;
      check("fwd1_x0", 64'(fwd1_hit), 64'd0);

      // Full queue accepts while the head retires
      cyc(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd3);
      #3;
      check("full_accept", 64'(wb_ready), 64'd1);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd3);
      #3;
      check("full_cnt_hold", 64'(count), 64'd4);
      drain_all();

      // x0 write is handshaked and dropped
      cyc(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0);
      #3;
      check("x0_ready", 64'(wb_ready), 64'd1);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      #3;
      check("x0_count", 64'(count), 64'd0);
      check("x0_we", 64'(regf_we), 64'd0);

      // Reset mid-drain
      cyc(1'b1, 5'd10, 32'hA, 1'b0, 5'd0, 5'd0);
      cyc(1'b1, 5'd11, 32'hB, 1'b0, 5'd0, 5'd0);
      cyc(1'b1, 5'd12, 32'hC, 1'b0, 5'd0, 5'd0);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 5'd12);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 5'd12);
      rst = 1'b1;
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 5'd12);
      rst = 1'b0;
      #3;
      check("rst_we", 64'(regf_we), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_fwd", 64'({fwd1_hit, fwd2_hit}), 64'd0);
      cyc(1'b1, 5'd1, 32'd7, 1'b1, 5'd1, 5'd0);
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      #3;
      check("post_rst_rd_s", 64'(rd_s), 64'd1);
      check("post_rst_rd_v", 64'(rd_v), 64'd7);
      drain_all();

      // Random traffic against the scoreboard
      for (int i = 0; i < 300; i++) begin
         cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      drain_all();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side front end of the integer register file.
- Buffers completed results (rd_s, rd_v) from the writeback stage in a small in-order FIFO and retires at most one entry per cycle onto the register file write port (regf_we/rd_s/rd_v).
- Provides combinational forwarding of pending values to the two decode read ports, so readers never see stale register-file data while a write is queued.

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_valid  in  1  result offered by writeback
- wb_ready  out  1  queue can accept this cycle
- wb_rd_s  in  5  destination register index
- wb_rd_v  in  32  destination value
- drain_en  in  1  permit retirement to regfile this cycle
- regf_we  out  1  register file write enable
- rd_s  out  5  register file write index
- rd_v  out  32  register file write data
- rs1_s  in  5  decode read index 1
- rs2_s  in  5  decode read index 2
- fwd1_hit  out  1  rs1_s matches a pending entry
- fwd1_v  out  32  forwarded value for rs1_s
- fwd2_hit  out  1  rs2_s matches a pending entry
- fwd2_v  out  32  forwarded value for rs2_s
- count  out  $clog2(DEPTH)+1  number of valid entries
- empty  out  1  count == 0

Behaviour:
Reset and storage:
- Reset clears head/tail pointers and count, and invalidates all entries.
- During and after reset, until the first enqueue: regf_we=0, rd_s=0, rd_v=0, count=0, empty=1, fwd*_hit=0, fwd*_v=0.
- wb_ready=0 while rst is high.
- Circular buffer of DEPTH entries {idx[4:0], val[31:0]}. Pointers wrap modulo DEPTH. count distinguishes full from empty.

Enqueue:
- Enqueue fires on wb_valid && wb_ready at a clock edge.
- wb_ready = !rst && (count < DEPTH || regf_we). A full queue accepts a new entry in the same cycle the head retires.
- Entries with wb_rd_s == 0 complete the handshake but are discarded: no storage, count unchanged.

Retire:
- regf_we = !empty && drain_en.
- rd_s/rd_v = head entry when !empty, otherwise 0.
- Outputs are combinational from the registered head. The entry dequeues at the edge where regf_we=1.
- Latency: an entry accepted at edge N appears on rd_s/rd_v in the cycle after edge N at the earliest, when the queue was empty.
- Strict FIFO order. drain_en=0 holds the head and all outputs stable.

Simultaneous events:
- Enqueue and retire in the same cycle: count unchanged, both pointers advance.
- Enqueue into an empty queue is not bypassed to regf_we in the same cycle.

Forwarding (combinational):
- For each read port, search all valid entries, including the head being written this cycle, since the regfile updates only at the next edge.
- The youngest matching entry wins.
- rsX_s == 0 always gives hit=0, v=0.
- No match gives hit=0, v=0.
- Incoming wb_* signals are not searched; there is no combinational path from wb_* to fwd*.
- Decode selects fwdX_v over regfile data when fwdX_hit=1.

count/empty:
- count and empty are registered and update at the edge.

Reset mid-operation:
- Pending entries are dropped. The regfile itself is cleared by the same reset.

Test Plan:
- Reset, then idle: regf_we=0, rd_s=0, rd_v=0, empty=1, wb_ready=1 in the first cycle after rst deasserts.
- drain_en=1; enqueue (x5, 0xDEADBEEF): next cycle regf_we=1, rd_s=5, rd_v=0xDEADBEEF; the cycle after, empty=1.
- drain_en=0; enqueue x3=1, x4=2, x3=3, x7=4: count=4, wb_ready=0.
  - rs1_s=3 gives fwd1_hit=1, fwd1_v=3.
  - rs2_s=7 gives fwd2_v=4.
  - rs1_s=0 gives hit=0.
  - drain_en=1 retires x3=1, x4=2, x3=3, x7=4 in order on consecutive cycles.
- Full queue, drain_en=1, wb_valid with (x9, 0x55): wb_ready=1, count stays 4, and x9 retires last.
- Enqueue wb_rd_s=0, value 0x1234: handshake completes, count unchanged, no regf_we. rs1_s=0 forwards hit=0.
- Fill 3 entries, assert rst for one cycle mid-drain: regf_we=0, count=0, fwd hits=0 afterwards. A subsequent enqueue of (x1, 7) retires normally.
